mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the instruction-fetch refill path (read-only) and the data-cache refill/writeback path (read/write).
- Grants one line-burst transaction at a time and sequences its address phase, then its write-data or read-data phase.
- Sits between the i-cache/d-cache miss handlers and the memory bus; uses the package MemAccessType encoding (WRITE=0, READ=1).

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width
LINE_WORDS, 4, words per burst; power of two, >=2

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low (already decided)
i_req_valid  in  1  instruction-side line read request
i_req_addr  in  ADDR_W  instruction-side line address
i_req_ready  out  1  1-cycle accept pulse to instruction side
i_rdata  out  DATA_W  read word to instruction side
i_rvalid  out  1  i_rdata valid
i_rlast  out  1  last word of instruction burst
d_req_valid  in  1  data-side request
d_req_type  in  1  MemAccessType (WRITE/READ)
d_req_addr  in  ADDR_W  data-side line address
d_req_ready  out  1  1-cycle accept pulse to data side
d_wdata  in  DATA_W  current writeback word, held until popped
d_wdata_ready  out  1  pop strobe: d_wdata consumed this cycle
d_rdata  out  DATA_W  read word to data side
d_rvalid  out  1  d_rdata valid
d_rlast  out  1  last word of data burst
mem_req_valid  out  1  address phase valid
mem_req_ready  in  1  memory accepts address
mem_req_type  out  1  MemAccessType of granted burst
mem_req_addr  out  ADDR_W  line-aligned burst address
mem_wvalid  out  1  write word valid
mem_wready  in  1  memory accepts write word
mem_wdata  out  DATA_W  write word
mem_rvalid  in  1  read word valid
mem_rdata  in  DATA_W  read word
busy  out  1  1 when state != IDLE
owner  out  1  0 = instruction side, 1 = data side (valid while busy)

Behaviour:
- FSM states: IDLE, ADDR, WDATA, RDATA.
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; word counter, owner, and latched addr/type clear to 0.
  - All outputs are 0 (the rdata buses are 0).
  - A burst in flight is abandoned; requesters must re-issue after reset.
- IDLE:
  - If any request is pending, select a winner and pulse the winner's *_req_ready combinationally in that cycle.
  - Latch owner, type (I side is always READ), and addr with its low log2(LINE_WORDS*DATA_W/8) bits zeroed.
  - Next state is ADDR.
  - Requesters hold valid/addr/type stable until ready.
- Default priority: data side wins when both are valid.
- ADDR:
  - mem_req_valid=1 with latched addr/type, held until mem_req_ready=1.
  - Next state is WDATA if WRITE, else RDATA.
- WDATA (owner is always the data side):
  - mem_wvalid=1; mem_wdata=d_wdata (combinational pass-through).
  - d_wdata_ready=mem_wready.
  - The counter increments on each mem_wready.
  - On the accept with counter==LINE_WORDS-1: counter clears, next state IDLE.
- RDATA:
  - mem_rdata/mem_rvalid are routed to the owner's rdata/rvalid; the other side sees rvalid=0.
  - The counter increments per mem_rvalid.
  - rlast=rvalid when counter==LINE_WORDS-1; then counter clears and next state is IDLE.
- mem_rvalid/mem_wready outside their phase are ignored.
- A request is never accepted while busy. The earliest new grant is the cycle after returning to IDLE, giving a 1-cycle bubble between bursts.
- Minimum burst latency, from accept to rlast: 1 (ADDR) + LINE_WORDS cycles.
- The counter is log2(LINE_WORDS) bits and never wraps mid-burst.

Optional Feature:
- Macro: MEM_PORT_ARB_RR_EN.
- Defined:
  - Round-robin selection when both sides request in IDLE: the side not granted last wins.
  - A last-grant flop resets to "instruction", so the data side wins the first conflict.
- Undefined: fixed data-side priority, and no last-grant flop exists.

Test Plan:
- Reset with all inputs 0 -> all outputs 0, busy=0. Then i_req_valid=1, addr 0x0000_1234 -> i_req_ready pulse, mem_req_addr 0x0000_1230, mem_req_type=READ. Four mem_rvalid words 0xA0..0xA3 -> i_rvalid x4 with i_rdata 0xA0..0xA3, i_rlast only on 0xA3, busy=0 the next cycle.
- d WRITE to 0x100 with mem_wready toggling 1,0,1,1,0,1 -> exactly 4 d_wdata_ready pulses aligned to mem_wready=1, mem_wdata matches d_wdata on each, then IDLE.
- i and d valid in the same IDLE cycle, no macro -> d granted (owner=1). After d completes, i granted. Repeat back-to-back -> d always wins the conflict.
- Same conflict with MEM_PORT_ARB_RR_EN -> grants alternate d, i, d, i.
- mem_req_ready held 0 for 5 cycles -> mem_req_valid stays 1 with stable addr. Spurious mem_rvalid during ADDR -> no *_rvalid output, counter unchanged.
- rst_n asserted after 2 of 4 read words -> outputs 0 immediately, IDLE. A new i request after release completes a full 4-word burst.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Access-type encoding and the bundled bus between the arbiter, both cache miss
// handlers and the external memory port.
package mem_port_arbiter_pkg;
    typedef enum logic {
        MEM_WRITE = 1'b0,
        MEM_READ  = 1'b1
    } mem_access_t;
endpackage

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req_valid;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_req_ready;
    logic [DATA_W-1:0] i_rdata;
    logic              i_rvalid;
    logic              i_rlast;

    logic              d_req_valid;
    logic              d_req_type;
    logic [ADDR_W-1:0] d_req_addr;
    logic              d_req_ready;
    logic [DATA_W-1:0] d_wdata;
    logic              d_wdata_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;
    logic              d_rlast;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_type;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    // Arbiter side: masters the memory port, serves both requesters.
    modport master (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_rdata, i_rvalid, i_rlast,
        input  d_req_valid, d_req_type, d_req_addr, d_wdata,
        output d_req_ready, d_wdata_ready, d_rdata, d_rvalid, d_rlast,
        output mem_req_valid, mem_req_type, mem_req_addr, mem_wvalid, mem_wdata,
        input  mem_req_ready, mem_wready, mem_rvalid, mem_rdata,
        output busy, owner
    );

    modport slave (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_rdata, i_rvalid, i_rlast,
        output d_req_valid, d_req_type, d_req_addr, d_wdata,
        input  d_req_ready, d_wdata_ready, d_rdata, d_rvalid, d_rlast,
        input  mem_req_valid, mem_req_type, mem_req_addr, mem_wvalid, mem_wdata,
        output mem_req_ready, mem_wready, mem_rvalid, mem_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between i-cache refill and d-cache refill/writeback,
// one line burst at a time. Define MEM_PORT_ARB_RR_EN for round-robin conflict resolution.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int OFF_W = $clog2(LINE_WORDS * DATA_W / 8);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              own_d;
    mem_access_t       req_type;
    logic [ADDR_W-1:0] req_addr;
    logic              req_valid;
    logic              wvalid;
    logic              busy_q;
    logic              grant;
    logic              pick_d;
    logic              last_beat;
    logic              rd_i;
    logic              rd_d;

`ifdef MEM_PORT_ARB_RR_EN
    logic last_d;

    // On a conflict the side that did not win the previous grant goes first.
    assign pick_d = bus.d_req_valid && !(bus.i_req_valid && last_d);
`else
    assign pick_d = bus.d_req_valid;
`endif

    // Holding off grants during reset keeps every output quiet while rst_n is low.
    assign grant     = rst_n && (state == IDLE) && (bus.i_req_valid || bus.d_req_valid);
    assign last_beat = (cnt == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            own_d     <= 1'b0;
            req_type  <= MEM_WRITE;
            req_addr  <= '0;
            req_valid <= 1'b0;
            wvalid    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
            last_d    <= 1'b0;
`endif
        end else begin
            // NOTE: every flop here uses <= so each branch sees pre-edge values, not a
            // half-updated mix from earlier statements in the same block.
            case (state)
                IDLE: if (grant) begin
                    state     <= ADDR;
                    busy_q    <= 1'b1;
                    req_valid <= 1'b1;
                    own_d     <= pick_d;
                    req_type  <= pick_d ? mem_access_t'(bus.d_req_type) : MEM_READ;
                    req_addr  <= (pick_d ? bus.d_req_addr : bus.i_req_addr) & LINE_MASK;
`ifdef MEM_PORT_ARB_RR_EN
                    last_d    <= pick_d;
`endif
                end
                ADDR: if (bus.mem_req_ready) begin
                    req_valid <= 1'b0;
                    if (req_type == MEM_WRITE) begin
                        state  <= WDATA;
                        wvalid <= 1'b1;
                    end else begin
                        state  <= RDATA;
                    end
                end
                WDATA: if (bus.mem_wready) begin
                    if (last_beat) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        wvalid <= 1'b0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt    <= cnt + 1'b1;
                    end
                end
                RDATA: if (bus.mem_rvalid) begin
                    if (last_beat) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt    <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_i = (state == RDATA) && !own_d;
    assign rd_d = (state == RDATA) && own_d;

    assign bus.i_req_ready   = grant && !pick_d;
    assign bus.d_req_ready   = grant && pick_d;

    assign bus.i_rvalid      = rd_i && bus.mem_rvalid;
    assign bus.i_rdata       = rd_i ? bus.mem_rdata : '0;
    assign bus.i_rlast       = bus.i_rvalid && last_beat;
    assign bus.d_rvalid      = rd_d && bus.mem_rvalid;
    assign bus.d_rdata       = rd_d ? bus.mem_rdata : '0;
    assign bus.d_rlast       = bus.d_rvalid && last_beat;

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_type  = req_type;
    assign bus.mem_req_addr  = req_addr;
    assign bus.mem_wvalid    = wvalid;
    assign bus.mem_wdata     = wvalid ? bus.d_wdata : '0;
    assign bus.d_wdata_ready = wvalid && bus.mem_wready;

    assign bus.busy          = busy_q;
    assign bus.owner         = own_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner-case
// sequences and randomized bursts checked against a transaction-level model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int          LINE_WORDS = 4;
    localparam logic [31:0] LINE_MASK  = 32'hFFFF_FFF0;  // 4 words x 4 bytes per line

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LINE_WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        iv;
        logic        dv;
        logic        dt;
        logic [31:0] ia;
        logic [31:0] da;
        logic        exp_i;
        logic        exp_d;
        logic [31:0] exp_addr;
        logic        exp_type;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        last_d_model = 1'b0;
    int          gap_pct = 0;
    bit          go_pat[$];
    logic [31:0] rwords[LINE_WORDS];
    logic [31:0] wwords[LINE_WORDS];
    vec_t        vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_req_valid   = 1'b0;
        bus.i_req_addr    = '0;
        bus.d_req_valid   = 1'b0;
        bus.d_req_type    = 1'b0;
        bus.d_req_addr    = '0;
        bus.d_wdata       = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_wready    = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = '0;
    endtask

    task automatic new_words();
        for (int i = 0; i < LINE_WORDS; i++) begin
            rwords[i] = $urandom;
            wwords[i] = $urandom;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".i_req_ready"},   bus.i_req_ready, 0);
        check({tag, ".d_req_ready"},   bus.d_req_ready, 0);
        check({tag, ".i_rvalid"},      bus.i_rvalid, 0);
        check({tag, ".i_rlast"},       bus.i_rlast, 0);
        check({tag, ".i_rdata"},       bus.i_rdata, 0);
        check({tag, ".d_rvalid"},      bus.d_rvalid, 0);
        check({tag, ".d_rlast"},       bus.d_rlast, 0);
        check({tag, ".d_rdata"},       bus.d_rdata, 0);
        check({tag, ".d_wdata_ready"}, bus.d_wdata_ready, 0);
        check({tag, ".mem_req_valid"}, bus.mem_req_valid, 0);
        check({tag, ".mem_req_type"},  bus.mem_req_type, 0);
        check({tag, ".mem_req_addr"},  bus.mem_req_addr, 0);
        check({tag, ".mem_wvalid"},    bus.mem_wvalid, 0);
        check({tag, ".mem_wdata"},     bus.mem_wdata, 0);
        check({tag, ".busy"},          bus.busy, 0);
        check({tag, ".owner"},         bus.owner, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        last_d_model = 1'b0;
    endtask

    // Winner choice from the arbitration rules: data side by default, alternation on
    // conflicts when round-robin is built in.
    function automatic logic model_pick_d(input logic iv, input logic dv);
`ifdef MEM_PORT_ARB_RR_EN
        if (iv && dv) return !last_d_model;
`endif
        return dv;
    endfunction

    // One IDLE cycle: present the requests, check who is accepted, winner drops its
    // request while the loser keeps asking.
    task automatic request_phase(input logic iv, input logic dv, input logic dt,
                                 input logic [31:0] ia, input logic [31:0] da,
                                 input logic exp_i, input logic exp_d);
        bus.i_req_valid = iv;
        bus.d_req_valid = dv;
        bus.d_req_type  = dt;
        bus.i_req_addr  = ia;
        bus.d_req_addr  = da;
        settle();
        check("i_req_ready", bus.i_req_ready, exp_i);
        check("d_req_ready", bus.d_req_ready, exp_d);
        step();
        if (exp_i) bus.i_req_valid = 1'b0;
        if (exp_d) bus.d_req_valid = 1'b0;
    endtask

    // Address phase with `delay` stall cycles; spurious data strobes are driven throughout.
    task automatic addr_phase(input logic [31:0] exp_addr, input logic exp_type,
                              input logic exp_own, input int delay);
        for (int k = 0; k <= delay; k++) begin
            bus.mem_req_ready = (k == delay);
            bus.mem_rvalid    = 1'b1;
            bus.mem_wready    = 1'b1;
            bus.mem_rdata     = $urandom;
            settle();
            check("addr.mem_req_valid", bus.mem_req_valid, 1);
            check("addr.mem_req_addr",  bus.mem_req_addr, exp_addr);
            check("addr.mem_req_type",  bus.mem_req_type, exp_type);
            check("addr.owner",         bus.owner, exp_own);
            check("addr.busy",          bus.busy, 1);
            check("addr.i_rvalid",      bus.i_rvalid, 0);
            check("addr.d_rvalid",      bus.d_rvalid, 0);
            check("addr.d_wdata_ready", bus.d_wdata_ready, 0);
            check("addr.mem_wvalid",    bus.mem_wvalid, 0);
            check("addr.i_req_ready",   bus.i_req_ready, 0);
            check("addr.d_req_ready",   bus.d_req_ready, 0);
            step();
        end
        bus.mem_req_ready = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_wready    = 1'b0;
    endtask

    // Data phase: LINE_WORDS accepted beats, stalls from go_pat or gap_pct.
    task automatic data_phase(input logic wr, input logic own_d);
        int beats = 0;
        int cyc   = 0;
        while (beats < LINE_WORDS && cyc < 64) begin
            logic go;
            if (go_pat.size() > 0) go = go_pat.pop_front();
            else                   go = ($urandom_range(0, 99) >= gap_pct);
            if (wr) begin
                bus.d_wdata    = wwords[beats];
                bus.mem_wready = go;
                bus.mem_rvalid = 1'($urandom_range(0, 1));
                settle();
                check("wr.mem_wvalid",    bus.mem_wvalid, 1);
                check("wr.mem_wdata",     bus.mem_wdata, wwords[beats]);
                check("wr.d_wdata_ready", bus.d_wdata_ready, go);
                check("wr.d_rvalid",      bus.d_rvalid, 0);
            end else begin
                bus.mem_rvalid = go;
                bus.mem_rdata  = go ? rwords[beats] : $urandom;
                bus.mem_wready = 1'($urandom_range(0, 1));
                settle();
                check("rd.i_rvalid",      bus.i_rvalid, go && !own_d);
                check("rd.d_rvalid",      bus.d_rvalid, go && own_d);
                check("rd.d_wdata_ready", bus.d_wdata_ready, 0);
                if (go) begin
                    check("rd.rdata", own_d ? bus.d_rdata : bus.i_rdata, rwords[beats]);
                    check("rd.rlast", own_d ? bus.d_rlast : bus.i_rlast, beats == LINE_WORDS - 1);
                    check("rd.other_rlast", own_d ? bus.i_rlast : bus.d_rlast, 0);
                end
            end
            step();
            if (go) beats++;
            cyc++;
        end
        if (beats < LINE_WORDS) check("burst_timeout", beats, LINE_WORDS);
        clear_inputs();
        settle();
        check("end.busy",          bus.busy, 0);
        check("end.mem_wvalid",    bus.mem_wvalid, 0);
        check("end.mem_req_valid", bus.mem_req_valid, 0);
    endtask

    task automatic do_txn(input logic iv, input logic dv, input logic dt,
                          input logic [31:0] ia, input logic [31:0] da, input int delay);
        logic pd;
        if (!iv && !dv) begin
            request_phase(iv, dv, dt, ia, da, 1'b0, 1'b0);
            return;
        end
        pd = model_pick_d(iv, dv);
        request_phase(iv, dv, dt, ia, da, !pd, pd);
        last_d_model = pd;
        addr_phase((pd ? da : ia) & LINE_MASK, pd ? dt : 1'b1, pd, delay);
        data_phase(pd && !dt, pd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_seq;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0,          1'b1, 1'b0, 32'h0000_1230, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0,          32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEE0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,          32'h0000_010C, 1'b0, 1'b1, 32'h0000_0100, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h1111_1111,  32'h2222_2222, 1'b0, 1'b0, 32'h0,         1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF,  32'h0,          1'b1, 1'b0, 32'hFFFF_FFF0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0,          32'h0000_000F, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h8000_0008,  32'h0,          1'b1, 1'b0, 32'h8000_0000, 1'b1};

        clear_inputs();
        do_reset();

        // Instruction read of 0x1234 with words 0xA0..0xA3.
        rwords = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        request_phase(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 1'b1, 1'b0);
        last_d_model = 1'b0;
        addr_phase(32'h0000_1230, 1'b1, 1'b0, 0);
        data_phase(1'b0, 1'b0);

        // Data writeback to 0x100 with mem_wready 1,0,1,1,0,1.
        new_words();
        go_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        request_phase(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 1'b0, 1'b1);
        last_d_model = 1'b1;
        addr_phase(32'h0000_0100, 1'b0, 1'b1, 0);
        data_phase(1'b1, 1'b1);

        // Directed vector table, no stalls.
        gap_pct = 0;
        foreach (vecs[n]) begin
            new_words();
            request_phase(vecs[n].iv, vecs[n].dv, vecs[n].dt, vecs[n].ia, vecs[n].da,
                          vecs[n].exp_i, vecs[n].exp_d);
            if (!vecs[n].exp_i && !vecs[n].exp_d) begin
                settle();
                check("vec.no_grant_busy", bus.busy, 0);
                clear_inputs();
            end else begin
                last_d_model = vecs[n].exp_d;
                addr_phase(vecs[n].exp_addr, vecs[n].exp_type, vecs[n].exp_d, 1);
                data_phase(!vecs[n].exp_type, vecs[n].exp_d);
            end
        end

        // Address stall of 5 cycles with spurious data strobes; burst must still be 4 beats.
        new_words();
        request_phase(1'b1, 1'b0, 1'b0, 32'h0000_5678, 32'h0, 1'b1, 1'b0);
        last_d_model = 1'b0;
        addr_phase(32'h0000_5670, 1'b1, 1'b0, 5);
        data_phase(1'b0, 1'b0);

        // Back-to-back conflicts from a fresh reset, loser holding its request.
`ifdef MEM_PORT_ARB_RR_EN
        exp_seq = 4'b0101;
`else
        exp_seq = 4'b1111;
`endif
        do_reset();
        for (int k = 0; k < 4; k++) begin
            new_words();
            request_phase(1'b1, 1'b1, 1'b1, 32'h0000_2004, 32'h0000_3008, !exp_seq[k], exp_seq[k]);
            last_d_model = exp_seq[k];
            addr_phase(exp_seq[k] ? 32'h0000_3000 : 32'h0000_2000, 1'b1, exp_seq[k], 0);
            data_phase(1'b0, exp_seq[k]);
        end
        new_words();
        do_txn(1'b1, 1'b0, 1'b0, 32'h0000_2004, 32'h0, 0);

        // Reset in the middle of an instruction burst after 2 of 4 words.
        new_words();
        request_phase(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 1'b0);
        addr_phase(32'h0000_0040, 1'b1, 1'b0, 0);
        for (int b = 0; b < 2; b++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rwords[b];
            step();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rwords[2];
        bus.d_wdata    = 32'hCAFE_F00D;
        settle();
        check("pre_rst.i_rvalid", bus.i_rvalid, 1);
        rst_n = 1'b0;
        settle();
        check_all_zero("mid_rst");
        step();
        clear_inputs();
        rst_n = 1'b1;
        last_d_model = 1'b0;
        new_words();
        do_txn(1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 0);

        // Randomized traffic against the transaction model.
        gap_pct = 30;
        for (int r = 0; r < 60; r++) begin
            new_words();
            do_txn(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
